// File: rtl/led_scan_controller.sv
// 4-digit 7-segment scan controller.
// Rotates through enabled digits with a blanking gap before each drive.
module led_scan_controller #(
  parameter int TICK_DIV     = 50000,
  parameter int BLANK_CYCLES = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [3:0] digit_en,
  output logic [1:0] seg_sel,
  output logic [3:0] anode,
  output logic       frame_start
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] TICK_LAST  = CW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    DRIVE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    sel_q, sel_d;
  logic [3:0]    anode_q, anode_d;
  logic          fs_q, fs_d;

  logic [1:0]    first_idx;
  logic [1:0]    next_idx;
  logic [1:0]    cand;
  logic          found;
  logic          run_ok;

  assign run_ok = en && (digit_en != 4'b0000);

  // Lowest enabled digit, used when a frame starts from IDLE.
  always_comb begin
    first_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (digit_en[i]) first_idx = 2'(i);
    end
  end

  // Next enabled digit above the current one, wrapping; self last.
  always_comb begin
    next_idx = sel_q;
    found    = 1'b0;
    cand     = sel_q;
    for (int k = 1; k <= 4; k++) begin
      cand = sel_q + 2'(k);
      if (!found && digit_en[cand]) begin
        next_idx = cand;
        found    = 1'b1;
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    sel_d   = sel_q;
    anode_d = anode_q;
    fs_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d   = '0;
        anode_d = 4'b1111;
        if (run_ok) begin
          state_d = BLANK;
          sel_d   = first_idx;
          fs_d    = 1'b1;
        end
      end
      BLANK: begin
        if (!run_ok) begin
          state_d = IDLE;
          cnt_d   = '0;
          anode_d = 4'b1111;
        end else if (cnt_q == BLANK_LAST) begin
          state_d = DRIVE;
          anode_d = ~(4'b0001 << sel_q);
        end
      end
      DRIVE: begin
        if (!run_ok) begin
          state_d = IDLE;
          cnt_d   = '0;
          anode_d = 4'b1111;
        end else if (cnt_q == TICK_LAST) begin
          state_d = BLANK;
          cnt_d   = '0;
          anode_d = 4'b1111;
          sel_d   = next_idx;
          fs_d    = (next_idx <= sel_q);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        anode_d = 4'b1111;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= 2'd0;
      anode_q <= 4'b1111;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      anode_q <= anode_d;
      fs_q    <= fs_d;
    end
  end

  assign seg_sel     = sel_q;
  assign anode       = anode_q;
  assign frame_start = fs_q;

endmodule
